// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// muldiv_seq: iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// Multiply is shift-add and divide is restoring. Each takes XLEN iteration cycles,
// framed by one PREP cycle (magnitudes and signs) and one FIX cycle (sign correction
// and result select). Divide-by-zero and signed overflow finish straight from PREP.
//
// Handshake: start is sampled only in IDLE, and only when flush is low. stall is
// raised in the start cycle and stays high through FIX. done is a one-cycle pulse,
// and result/rd_out are valid while it is high. result/rd_out keep their value until
// the next operation completes. flush abandons any operation in flight and does not
// touch result/rd_out.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,      // asynchronous, active low
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic [2:0]      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]     LP_CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   LP_ONE      = XLEN'(1);
    localparam logic [2*XLEN-1:0] LP_ONE2     = (2*XLEN)'(1);
    localparam logic [XLEN-1:0]   LP_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [4:0]          r_rd;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]     r_dvs;      // multiplicand or divisor magnitude
    logic                r_neg_q;    // negate product / quotient in FIX
    logic                r_neg_r;    // negate remainder in FIX
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;
    logic                r_done;

    // ---------------- operand decode (used in PREP) ----------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_is_div   = r_funct3[2];
    // MULH, MULHSU, DIV and REM treat op_a as signed; MULHSU leaves op_b unsigned.
    assign w_a_signed = (r_funct3 == 3'b001) || (r_funct3 == 3'b010) ||
                        (r_funct3 == 3'b100) || (r_funct3 == 3'b110);
    assign w_b_signed = (r_funct3 == 3'b001) || (r_funct3 == 3'b100) ||
                        (r_funct3 == 3'b110);
    assign w_sa       = w_a_signed & r_a[XLEN-1];
    assign w_sb       = w_b_signed & r_b[XLEN-1];
    assign w_mag_a    = w_sa ? (~r_a + LP_ONE) : r_a;
    assign w_mag_b    = w_sb ? (~r_b + LP_ONE) : r_b;
    assign w_div_zero = (r_b == '0);
    assign w_ovf      = ((r_funct3 == 3'b100) || (r_funct3 == 3'b110)) &&
                        (r_a == LP_MIN_NEG) && (r_b == '1);
    assign w_special  = w_is_div && (w_div_zero || w_ovf);
    // funct3[1] selects remainder. Div-by-zero: quotient all ones, remainder op_a.
    // Overflow: quotient op_a (the most negative value), remainder 0.
    assign w_special_res = w_div_zero ? (r_funct3[1] ? r_a : '1)
                                      : (r_funct3[1] ? '0  : r_a);

    // ---------------- one multiply iteration ----------------
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;

    assign w_addend   = r_acc[0] ? r_dvs : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // ---------------- one restoring-divide iteration ----------------
    logic [XLEN:0]     w_div_shl;    // remainder shifted left with the next dividend bit
    logic              w_div_ok;
    logic [XLEN-1:0]   w_div_trial;
    logic [2*XLEN-1:0] w_div_next;

    assign w_div_shl   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ok    = (w_div_shl >= {1'b0, r_dvs});
    assign w_div_trial = w_div_shl[XLEN-1:0] - r_dvs;
    assign w_div_next  = {(w_div_ok ? w_div_trial : w_div_shl[XLEN-1:0]),
                          r_acc[XLEN-2:0], w_div_ok};

    // ---------------- sign fix-up and result select ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod    = r_neg_q ? (~r_acc + LP_ONE2) : r_acc;
    assign w_quot    = r_neg_q ? (~r_acc[XLEN-1:0] + LP_ONE) : r_acc[XLEN-1:0];
    assign w_rem     = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + LP_ONE) : r_acc[2*XLEN-1:XLEN];
    assign w_fix_res = w_is_div ? (r_funct3[1] ? w_rem : w_quot)
                                : ((r_funct3 == 3'b000) ? w_prod[XLEN-1:0]
                                                        : w_prod[2*XLEN-1:XLEN]);

    // Sequencer FSM: operand capture, iteration, fix-up and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_funct3 <= funct3_in;
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_rd     <= rd_in;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_rd_out <= r_rd;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                            r_dvs   <= w_mag_b;
                            r_cnt   <= LP_CNT_LAST;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_is_div ? w_div_next : w_mul_next;
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_rd_out <= r_rd;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall     = (start && (r_state == S_IDLE)) ||
                       (r_state == S_PREP) || (r_state == S_CALC) || (r_state == S_FIX);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign rd_out    = r_rd_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// Testbench for muldiv_seq: directed RV32M cases, flush, reset mid-operation and
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .funct3_in (funct3_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle (caller is just past a rising edge) and
  // follows it to its done pulse, checking latency, stall length, result and rd.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noisy, input string tag);
    int done_cyc;
    int stall_cnt;
    int exp_cyc;
    exp_q.push_back(ref_result(f3, a, b));
    exp_rd_q.push_back(rd);
    exp_cyc   = is_special(f3, a, b) ? 2 : 35;
    done_cyc  = 0;
    stall_cnt = 0;
    start = 1'b1; funct3_in = f3; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    if (stall) stall_cnt++;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      next_cycle();
      if (cyc == 1) begin
        start = 1'b0;
        funct3_in = 3'($urandom);
        op_a = $urandom;
        op_b = $urandom;
        rd_in = 5'($urandom);
      end
      if (noisy && cyc == 5) start = 1'b1;
      if (noisy && cyc == 6) start = 1'b0;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = cyc;
        last_res = exp_q.pop_front();
        last_rd  = exp_rd_q.pop_front();
        check({tag, " result"}, result, last_res);
        check({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, last_rd});
      end
    end
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_cyc));
    if (done_cyc == 0) begin
      void'(exp_q.pop_front());
      void'(exp_rd_q.pop_front());
    end
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    int          done_seen;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    reset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3_in = '0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    check("reset stall",  {31'b0, stall}, 32'd0);
    check("reset busy",   {31'b0, busy},  32'd0);
    check("reset done",   {31'b0, done},  32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'b0, rd_out}, 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Directed operations
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  1'b0, "mul_7x-3");     next_cycle();
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1'b0, "mulhu_max");    next_cycle();
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b0, "mulh_-1");      next_cycle();
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  1'b0, "mulhsu");       next_cycle();
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  1'b0, "div_-7/2");     next_cycle();
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  1'b0, "rem_-7/2");     next_cycle();
    run_op(3'd5, 32'd100,        32'd7,         5'd7,  1'b1, "divu_100/7");   next_cycle();
    run_op(3'd7, 32'd100,        32'd7,         5'd8,  1'b1, "remu_100/7");   next_cycle();
    run_op(3'd5, 32'd5,          32'd0,         5'd9,  1'b0, "divu_by0");     next_cycle();
    run_op(3'd6, 32'd5,          32'd0,         5'd10, 1'b0, "rem_by0");      next_cycle();
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1'b0, "div_ovf");      next_cycle();
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1'b0, "rem_ovf");      next_cycle();
    run_op(3'd0, 32'd123456,     32'd789,       5'd13, 1'b0, "mul_pos");      next_cycle();

    // Flush in the 10th CALC cycle, with a stray start pulse while busy
    prev_res = last_res;
    prev_rd  = last_rd;
    done_seen = 0;
    start = 1'b1; funct3_in = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd20;
    @(negedge clk);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      next_cycle();
      if (cyc == 1) start = 1'b0;
      if (cyc == 5) begin start = 1'b1; op_a = 32'd77; end
      if (cyc == 6) start = 1'b0;
      if (cyc == 11) flush = 1'b1;
      @(negedge clk);
      if (done) done_seen++;
    end
    next_cycle();
    flush = 1'b0;
    check("flush busy",   {31'b0, busy}, 32'd0);
    check("flush done",   {31'b0, done}, 32'd0);
    check("flush no_done_pulse", 32'(done_seen), 32'd0);
    check("flush result_kept", result, prev_res);
    check("flush rd_kept", {27'b0, rd_out}, {27'b0, prev_rd});
    run_op(3'd7, 32'd1000, 32'd3, 5'd21, 1'b1, "after_flush");
    next_cycle();

    // Asynchronous reset in the middle of an operation
    start = 1'b1; funct3_in = 3'd0; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd22;
    @(negedge clk);
    for (int cyc = 1; cyc < 20; cyc++) begin
      next_cycle();
      if (cyc == 1) start = 1'b0;
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midreset stall",  {31'b0, stall}, 32'd0);
    check("midreset busy",   {31'b0, busy},  32'd0);
    check("midreset done",   {31'b0, done},  32'd0);
    check("midreset result", result, 32'd0);
    check("midreset rd_out", {27'b0, rd_out}, 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    run_op(3'd0, 32'd3, 32'd4, 5'd23, 1'b0, "mul_3x4");
    next_cycle();

    // Randomized operations, biased towards the divide corner cases
    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = 32'($urandom_range(0, 20));
      run_op(f3, a, b, 5'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d_f%0d", i, f3));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
